// File: rtl/gfp8_pkg.sv
// ---------------------------------------------------------------------------
// gfp8_pkg
// Shared definitions for the GFP8 NV accumulation path: default widths,
// the fixed-width NV dot term as produced by gfp8_nv_dot, and the state
// encoding of the accumulator FSM.
// ---------------------------------------------------------------------------
package gfp8_pkg;

    localparam int ACC_W_DEF  = 40;  // accumulator mantissa width (signed)
    localparam int EXP_W_DEF  = 8;   // exponent width (signed)
    localparam int CNT_W_DEF  = 8;   // NV count width
    localparam int NV_MANT_W  = 32;  // gfp8_nv_dot result mantissa width

    // One per-NV dot result at the default exponent width.
    typedef struct packed {
        logic signed [NV_MANT_W-1:0] mantissa;
        logic signed [EXP_W_DEF-1:0] exponent;
    } nv_term_t;

    // Accumulator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } accum_state_e;

endpackage

// File: rtl/gfp8_align_add.sv
// ---------------------------------------------------------------------------
// gfp8_align_add
// Purely combinational block-float align-and-add of one NV term into the
// running accumulator. The operand with the smaller exponent is shifted
// arithmetically right (floor toward -inf) to the larger exponent, the two
// are summed in ACC_W+1 bits and saturated back to ACC_W bits. Mantissas
// are never shifted left, so precision is only ever dropped, not gained.
//
// Ports
//   acc_mantissa   in   ACC_W  current accumulator mantissa (signed)
//   acc_exponent   in   EXP_W  current accumulator exponent (signed)
//   term_mantissa  in   32     incoming term mantissa (signed)
//   term_exponent  in   EXP_W  incoming term exponent (signed)
//   sum_mantissa   out  ACC_W  updated accumulator mantissa
//   sum_exponent   out  EXP_W  updated accumulator exponent
//   sat            out  1      this addition saturated
// ---------------------------------------------------------------------------
module gfp8_align_add
    import gfp8_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic signed [ACC_W-1:0]     acc_mantissa,
    input  logic signed [EXP_W-1:0]     acc_exponent,
    input  logic signed [NV_MANT_W-1:0] term_mantissa,
    input  logic signed [EXP_W-1:0]     term_exponent,
    output logic signed [ACC_W-1:0]     sum_mantissa,
    output logic signed [EXP_W-1:0]     sum_exponent,
    output logic                        sat
);

    // Arithmetic right shift; shifts of ACC_W or more leave only the sign.
    function automatic logic signed [ACC_W-1:0] asr(
        input logic signed [ACC_W-1:0] v,
        input logic        [EXP_W:0]   sh
    );
        logic signed [ACC_W-1:0] r;
        if (int'(sh) >= ACC_W) begin
            r = {ACC_W{v[ACC_W-1]}};
        end else begin
            r = v >>> sh;
        end
        return r;
    endfunction

    logic signed [ACC_W-1:0] term_ext_s;
    logic signed [EXP_W:0]   diff_s;
    logic        [EXP_W:0]   shamt_s;
    logic                    acc_larger_s;
    logic signed [ACC_W-1:0] acc_al_s;
    logic signed [ACC_W-1:0] term_al_s;
    logic signed [ACC_W:0]   sum_x_s;
    logic signed [ACC_W-1:0] sat_max_s;
    logic signed [ACC_W-1:0] sat_min_s;

    assign term_ext_s   = {{(ACC_W-NV_MANT_W){term_mantissa[NV_MANT_W-1]}}, term_mantissa};
    // One extra bit so the exponent difference can never wrap.
    assign diff_s       = {acc_exponent[EXP_W-1], acc_exponent}
                        - {term_exponent[EXP_W-1], term_exponent};
    assign acc_larger_s = ~diff_s[EXP_W];
    assign shamt_s      = acc_larger_s ? diff_s : -diff_s;
    assign sum_x_s      = {acc_al_s[ACC_W-1], acc_al_s} + {term_al_s[ACC_W-1], term_al_s};
    assign sat_max_s    = {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_min_s    = {1'b1, {(ACC_W-1){1'b0}}};

    // Align the operand with the smaller exponent to the larger one.
    always_comb begin
        acc_al_s  = acc_mantissa;
        term_al_s = term_ext_s;
        if (acc_larger_s) begin
            term_al_s = asr(term_ext_s, shamt_s);
        end else begin
            acc_al_s = asr(acc_mantissa, shamt_s);
        end
    end

    // Select load / hold / saturating sum for the accumulator update.
    always_comb begin
        sum_mantissa = acc_mantissa;
        sum_exponent = acc_exponent;
        sat          = 1'b0;
        if (acc_mantissa == {ACC_W{1'b0}}) begin
            // Empty (or cancelled-to-zero) accumulator takes the term as is.
            sum_mantissa = term_ext_s;
            sum_exponent = term_exponent;
        end else if (term_mantissa == {NV_MANT_W{1'b0}}) begin
            // A zero term must not raise the exponent and lose precision.
            sum_mantissa = acc_mantissa;
            sum_exponent = acc_exponent;
        end else begin
            sum_exponent = acc_larger_s ? acc_exponent : term_exponent;
            if (sum_x_s[ACC_W] != sum_x_s[ACC_W-1]) begin
                sat          = 1'b1;
                sum_mantissa = sum_x_s[ACC_W] ? sat_min_s : sat_max_s;
            end else begin
                sum_mantissa = sum_x_s[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gfp8_nv_accum.sv
// ---------------------------------------------------------------------------
// gfp8_nv_accum
// Accumulates a programmed number of per-NV dot results (mantissa,
// exponent) into one block-float GEMM output element and offers it on a
// valid/ready port. The last accepted term lands in the accumulator on one
// edge; the result becomes valid after the following edge.
//
// Ports
//   i_clk              in   1      clock
//   i_reset_n          in   1      synchronous active-low reset
//   i_start            in   1      begin new element (honoured only in IDLE)
//   i_num_nv           in   CNT_W  term count, latched with i_start
//   i_nv_valid         in   1      term valid, one per cycle
//   i_nv_mantissa      in   32     signed term mantissa
//   i_nv_exponent      in   EXP_W  signed term exponent
//   o_busy             out  1      element in progress or awaiting accept
//   o_result_valid     out  1      result held until accepted
//   i_result_ready     in   1      consumer accept
//   o_result_mantissa  out  ACC_W  signed accumulated mantissa
//   o_result_exponent  out  EXP_W  signed result exponent
//   o_overflow         out  1      saturation seen during this element
// ---------------------------------------------------------------------------
module gfp8_nv_accum
    import gfp8_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic        [CNT_W-1:0]     i_num_nv,
    input  logic                        i_nv_valid,
    input  logic signed [NV_MANT_W-1:0] i_nv_mantissa,
    input  logic signed [EXP_W-1:0]     i_nv_exponent,
    output logic                        o_busy,
    output logic                        o_result_valid,
    input  logic                        i_result_ready,
    output logic signed [ACC_W-1:0]     o_result_mantissa,
    output logic signed [EXP_W-1:0]     o_result_exponent,
    output logic                        o_overflow
);

    accum_state_e            state_r;
    accum_state_e            state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [EXP_W-1:0] exp_r;
    logic                    ovf_r;
    logic                    busy_r;
    logic                    valid_r;

    logic                    start_take_s;
    logic                    term_take_s;
    logic signed [ACC_W-1:0] sum_mant_s;
    logic signed [EXP_W-1:0] sum_exp_s;
    logic                    sum_sat_s;

    assign start_take_s = (state_r == ST_IDLE) && i_start;
    // Once the count is exhausted, further valids in ACCUM are dropped.
    assign term_take_s  = (state_r == ST_ACCUM) && (cnt_r != {CNT_W{1'b0}}) && i_nv_valid;

    gfp8_align_add #(
        .ACC_W (ACC_W),
        .EXP_W (EXP_W)
    ) u_align_add (
        .acc_mantissa  (acc_r),
        .acc_exponent  (exp_r),
        .term_mantissa (i_nv_mantissa),
        .term_exponent (i_nv_exponent),
        .sum_mantissa  (sum_mant_s),
        .sum_exponent  (sum_exp_s),
        .sat           (sum_sat_s)
    );

    // Next-state decode; an exhausted ACCUM steps to DONE on the next edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt_s = (i_num_nv == {CNT_W{1'b0}}) ? ST_DONE : ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (valid_r && i_result_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, accumulator and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            exp_r   <= {EXP_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            valid_r <= (state_nxt_s == ST_DONE);
            if (start_take_s) begin
                cnt_r <= i_num_nv;
                acc_r <= {ACC_W{1'b0}};
                exp_r <= {EXP_W{1'b0}};
                ovf_r <= 1'b0;
            end else if (term_take_s) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                acc_r <= sum_mant_s;
                exp_r <= sum_exp_s;
                ovf_r <= ovf_r | sum_sat_s;
            end else begin
                cnt_r <= cnt_r;
                acc_r <= acc_r;
                exp_r <= exp_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign o_busy            = busy_r;
    assign o_result_valid    = valid_r;
    assign o_result_mantissa = acc_r;
    assign o_result_exponent = exp_r;
    assign o_overflow        = ovf_r;

endmodule
